// File: rtl/neuron_layer_driver.sv
`default_nettype none
// ============================================================================
// Module   : neuron_layer_driver
// Purpose  : Sequences one layer through a single serial neuron. Latches a
//            layer command and an activation vector, fetches one weight row
//            per output neuron, drives the three neuron input channels, and
//            gathers each returned sum/overflow into the layer result.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_layer_driver #(
  parameter int NEURON_NUM          = 5,
  parameter int OUTPUT_NUM          = 4,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int WEIGHT_CELL_WIDTH   = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [$clog2(NEURON_NUM):0]               cmd_input_count,
  input  logic [$clog2(OUTPUT_NUM):0]               cmd_output_count,
  input  logic                                      cmd_valid,
  output logic                                      cmd_ready,
  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    activations,
  input  logic                                      activations_valid,
  output logic                                      activations_ready,
  output logic [$clog2(OUTPUT_NUM):0]               weight_addr,
  output logic                                      weight_addr_valid,
  input  logic                                      weight_addr_ready,
  input  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   weight_row,
  input  logic                                      weight_row_valid,
  output logic                                      weight_row_ready,
  output logic [$clog2(NEURON_NUM):0]               neuron_input_number,
  output logic                                      neuron_input_number_valid,
  input  logic                                      neuron_input_number_ready,
  output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    neuron_inputs,
  output logic                                      neuron_inputs_valid,
  input  logic                                      neuron_inputs_ready,
  output logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   neuron_weights,
  output logic                                      neuron_weights_valid,
  input  logic                                      neuron_weights_ready,
  input  logic [NEURON_OUTPUT_WIDTH-1:0]            neuron_sum,
  input  logic                                      neuron_overflow,
  input  logic                                      neuron_sum_valid,
  output logic                                      neuron_sum_ready,
  output logic [OUTPUT_NUM*NEURON_OUTPUT_WIDTH-1:0] layer_outputs,
  output logic [OUTPUT_NUM-1:0]                     layer_overflow,
  output logic                                      layer_valid,
  input  logic                                      layer_ready
);

  localparam int IN_CNT_W  = $clog2(NEURON_NUM) + 1;
  localparam int OUT_CNT_W = $clog2(OUTPUT_NUM) + 1;
  localparam logic [IN_CNT_W-1:0]  IN_MAX  = IN_CNT_W'(NEURON_NUM);
  localparam logic [OUT_CNT_W-1:0] OUT_MAX = OUT_CNT_W'(OUTPUT_NUM);
  localparam logic [OUT_CNT_W-1:0] ROW_ONE = OUT_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic                                      cmd_got, act_got;
  logic [IN_CNT_W-1:0]                       in_cnt;
  logic [OUT_CNT_W-1:0]                      out_cnt;
  logic [OUT_CNT_W-1:0]                      row;
  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    act_buf;
  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   weight_buf;
  logic [2:0]                                sent;   // {weights, inputs, number}
  logic [OUTPUT_NUM*NEURON_OUTPUT_WIDTH-1:0] result_buf;
  logic [OUTPUT_NUM-1:0]                     overflow_buf;

  logic                 cmd_fire, act_fire, addr_fire, row_fire, sum_fire, layer_fire;
  logic [2:0]           chan_fire;
  logic                 all_sent, last_row;
  logic [IN_CNT_W-1:0]  in_cnt_clamped, in_cnt_cur;
  logic [OUT_CNT_W-1:0] out_cnt_clamped, out_cnt_cur;

  // Handshake outputs are pure decodes of state and flags, so they are glitch-free of inputs.
  assign cmd_ready                 = (state == S_IDLE) && !cmd_got;
  assign activations_ready         = (state == S_IDLE) && !act_got;
  assign weight_addr               = row;
  assign weight_addr_valid         = (state == S_FETCH);
  assign weight_row_ready          = (state == S_LOAD);
  assign neuron_input_number       = in_cnt;
  assign neuron_input_number_valid = (state == S_SEND) && !sent[0];
  assign neuron_inputs             = act_buf;
  assign neuron_inputs_valid       = (state == S_SEND) && !sent[1];
  assign neuron_weights            = weight_buf;
  assign neuron_weights_valid      = (state == S_SEND) && !sent[2];
  assign neuron_sum_ready          = (state == S_WAIT);
  assign layer_outputs             = result_buf;
  assign layer_overflow            = overflow_buf;
  assign layer_valid               = (state == S_DONE);

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign act_fire   = activations_valid & activations_ready;
  assign addr_fire  = weight_addr_valid & weight_addr_ready;
  assign row_fire   = weight_row_valid & weight_row_ready;
  assign sum_fire   = neuron_sum_valid & neuron_sum_ready;
  assign layer_fire = layer_valid & layer_ready;
  assign chan_fire  = {neuron_weights_valid & neuron_weights_ready,
                       neuron_inputs_valid & neuron_inputs_ready,
                       neuron_input_number_valid & neuron_input_number_ready};
  assign all_sent   = &(sent | chan_fire);

  // A command landing this very cycle must already steer the IDLE exit decision.
  assign in_cnt_clamped  = (cmd_input_count > IN_MAX) ? IN_MAX : cmd_input_count;
  assign out_cnt_clamped = (cmd_output_count > OUT_MAX) ? OUT_MAX : cmd_output_count;
  assign in_cnt_cur      = cmd_fire ? in_cnt_clamped : in_cnt;
  assign out_cnt_cur     = cmd_fire ? out_cnt_clamped : out_cnt;
  assign last_row        = (row == out_cnt - ROW_ONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if ((cmd_got || cmd_fire) && (act_got || act_fire))
                 state_nxt = ((in_cnt_cur == '0) || (out_cnt_cur == '0)) ? S_DONE : S_FETCH;
      S_FETCH: if (addr_fire) state_nxt = S_LOAD;
      S_LOAD:  if (row_fire)  state_nxt = S_SEND;
      S_SEND:  if (all_sent)  state_nxt = S_WAIT;
      S_WAIT:  if (sum_fire)  state_nxt = last_row ? S_DONE : S_FETCH;
      S_DONE:  if (layer_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: input latches, weight buffer, channel flags, row counter and results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_got      <= 1'b0;
      act_got      <= 1'b0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      row          <= '0;
      act_buf      <= '0;
      weight_buf   <= '0;
      sent         <= '0;
      result_buf   <= '0;
      overflow_buf <= '0;
    end else if (layer_fire) begin
      cmd_got      <= 1'b0;
      act_got      <= 1'b0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      row          <= '0;
      act_buf      <= '0;
      weight_buf   <= '0;
      sent         <= '0;
      result_buf   <= '0;
      overflow_buf <= '0;
    end else begin
      if (cmd_fire) begin
        cmd_got <= 1'b1;
        in_cnt  <= in_cnt_clamped;
        out_cnt <= out_cnt_clamped;
      end
      if (act_fire) begin
        act_got <= 1'b1;
        act_buf <= activations;
      end
      if (row_fire) weight_buf <= weight_row;
      if (state == S_SEND) sent <= all_sent ? 3'b000 : (sent | chan_fire);
      if (sum_fire) begin
        for (int i = 0; i < OUTPUT_NUM; i++) begin
          if (row == OUT_CNT_W'(i)) begin
            result_buf[i*NEURON_OUTPUT_WIDTH +: NEURON_OUTPUT_WIDTH] <= neuron_sum;
            overflow_buf[i] <= neuron_overflow;
          end
        end
        if (!last_row) row <= row + ROW_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_layer_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_neuron_layer_driver
// Purpose  : Directed self-checking bench with weight-memory and neuron
//            responder models around neuron_layer_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_layer_driver;

  localparam int NN  = 5;
  localparam int ON  = 4;
  localparam int SW  = 10;
  localparam int AW  = 9;
  localparam int WW  = 16;
  localparam int ICW = $clog2(NN) + 1;
  localparam int OCW = $clog2(ON) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ICW-1:0]   cmd_input_count;
  logic [OCW-1:0]   cmd_output_count;
  logic             cmd_valid, cmd_ready;
  logic [NN*AW-1:0] activations;
  logic             activations_valid, activations_ready;
  logic [OCW-1:0]   weight_addr;
  logic             weight_addr_valid, weight_addr_ready;
  logic [NN*WW-1:0] weight_row;
  logic             weight_row_valid, weight_row_ready;
  logic [ICW-1:0]   neuron_input_number;
  logic             neuron_input_number_valid, neuron_input_number_ready;
  logic [NN*AW-1:0] neuron_inputs;
  logic             neuron_inputs_valid, neuron_inputs_ready;
  logic [NN*WW-1:0] neuron_weights;
  logic             neuron_weights_valid, neuron_weights_ready;
  logic [SW-1:0]    neuron_sum;
  logic             neuron_overflow, neuron_sum_valid, neuron_sum_ready;
  logic [ON*SW-1:0] layer_outputs;
  logic [ON-1:0]    layer_overflow;
  logic             layer_valid, layer_ready;

  neuron_layer_driver dut (
    .clk(clk), .rst(rst),
    .cmd_input_count(cmd_input_count), .cmd_output_count(cmd_output_count),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .activations(activations), .activations_valid(activations_valid),
    .activations_ready(activations_ready),
    .weight_addr(weight_addr), .weight_addr_valid(weight_addr_valid),
    .weight_addr_ready(weight_addr_ready),
    .weight_row(weight_row), .weight_row_valid(weight_row_valid),
    .weight_row_ready(weight_row_ready),
    .neuron_input_number(neuron_input_number),
    .neuron_input_number_valid(neuron_input_number_valid),
    .neuron_input_number_ready(neuron_input_number_ready),
    .neuron_inputs(neuron_inputs), .neuron_inputs_valid(neuron_inputs_valid),
    .neuron_inputs_ready(neuron_inputs_ready),
    .neuron_weights(neuron_weights), .neuron_weights_valid(neuron_weights_valid),
    .neuron_weights_ready(neuron_weights_ready),
    .neuron_sum(neuron_sum), .neuron_overflow(neuron_overflow),
    .neuron_sum_valid(neuron_sum_valid), .neuron_sum_ready(neuron_sum_ready),
    .layer_outputs(layer_outputs), .layer_overflow(layer_overflow),
    .layer_valid(layer_valid), .layer_ready(layer_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder model state
  logic [NN*WW-1:0] rom [ON];
  logic [SW-1:0]    sum_tab [ON];
  logic             ovf_tab [ON];
  int nidx, stall_row, wdelay, wcnt;
  int hi_n, hi_i, hi_w, viol, lv_count, last_num;
  logic [NN*AW-1:0] last_inputs;
  logic [NN*WW-1:0] last_weights;
  int addr_log [$];

  function automatic logic [NN*AW-1:0] pk_a(input int a0, a1, a2, a3, a4);
    pk_a = {AW'(a4), AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [NN*WW-1:0] pk_w(input int w0, w1, w2, w3, w4);
    pk_w = {WW'(w4), WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
  endfunction

  // Weight memory: returns the addressed row in the cycle after the address transfer.
  always @(negedge clk) begin
    int a;
    weight_row_valid = weight_row_ready;
    if (weight_addr_valid) begin
      a = int'(weight_addr);
      addr_log.push_back(a);
      weight_row = rom[a];
    end
  end

  // Neuron model: optional weights-channel skew, optional stalled row, observation counters.
  always @(negedge clk) begin
    if (neuron_input_number_valid) begin hi_n++; last_num = int'(neuron_input_number); end
    if (neuron_inputs_valid) begin hi_i++; last_inputs = neuron_inputs; end
    if (neuron_weights_valid) begin
      hi_w++; wcnt++; last_weights = neuron_weights;
      neuron_weights_ready = (wcnt > wdelay);
    end else begin
      wcnt = 0; neuron_weights_ready = 1'b0;
    end
    if (neuron_sum_ready && (neuron_input_number_valid || neuron_inputs_valid || neuron_weights_valid))
      viol++;
    if (neuron_sum_valid) begin
      neuron_sum_valid = 1'b0; nidx++;
    end else if (neuron_sum_ready && nidx != stall_row) begin
      neuron_sum = sum_tab[nidx]; neuron_overflow = ovf_tab[nidx]; neuron_sum_valid = 1'b1;
    end
    if (layer_valid) lv_count++;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic issue(input logic [ICW-1:0] ic, input logic [OCW-1:0] oc, input logic [NN*AW-1:0] acts);
    tick();
    cmd_input_count = ic; cmd_output_count = oc; activations = acts;
    cmd_valid = 1'b1; activations_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; activations_valid = 1'b0;
  endtask

  task automatic wait_layer(input string tag, output int cycles);
    cycles = 0;
    do begin tick(); cycles++; end while (!layer_valid && cycles < 300);
    if (!layer_valid) check({tag, " timeout"}, 64'(0), 64'(1));
  endtask

  task automatic new_test();
    nidx = 0; stall_row = -1; wdelay = 0; hi_n = 0; hi_i = 0; hi_w = 0; viol = 0;
    addr_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad, lv_before;
    logic [ON*SW-1:0] snap;
    cmd_input_count = '0; cmd_output_count = '0; cmd_valid = 0; activations = '0;
    activations_valid = 0; weight_addr_ready = 1; weight_row = '0; weight_row_valid = 0;
    neuron_input_number_ready = 1; neuron_inputs_ready = 1; neuron_weights_ready = 0;
    neuron_sum = '0; neuron_overflow = 0; neuron_sum_valid = 0; layer_ready = 1;
    wcnt = 0; lv_count = 0; last_num = 0; last_inputs = '0; last_weights = '0;
    for (int i = 0; i < ON; i++) begin rom[i] = '0; sum_tab[i] = '0; ovf_tab[i] = 0; end
    new_test();

    // Reset values
    tick(); tick();
    check("rst cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst activations_ready", 64'(activations_ready), 64'(1));
    check("rst handshake outs", 64'({weight_addr_valid, weight_row_ready, neuron_input_number_valid,
          neuron_inputs_valid, neuron_weights_valid, neuron_sum_ready, layer_valid}), 64'(0));
    check("rst weight_addr", 64'(weight_addr), 64'(0));
    check("rst neuron buses", 64'(neuron_inputs | neuron_input_number), 64'(0));
    check("rst layer_outputs", 64'(layer_outputs), 64'(0));
    check("rst layer_overflow", 64'(layer_overflow), 64'(0));
    rst = 1'b0;

    // Basic layer
    new_test();
    rom[0] = pk_w(1, 1, 1, 0, 0); rom[1] = pk_w(2, 0, -1, 0, 0);
    sum_tab[0] = 10'd6; sum_tab[1] = 10'h3FF; ovf_tab[0] = 0; ovf_tab[1] = 0;
    issue(4'd3, 3'd2, pk_a(1, 2, 3, 0, 0));
    wait_layer("basic", cyc);
    check("basic latency", 64'(cyc), 64'(9));
    check("basic addr count", 64'(addr_log.size()), 64'(2));
    check("basic addr0", 64'(addr_log[0]), 64'(0));
    check("basic addr1", 64'(addr_log[1]), 64'(1));
    check("basic input_number", 64'(last_num), 64'(3));
    check("basic inputs bus", 64'(last_inputs), 64'(pk_a(1, 2, 3, 0, 0)));
    check("basic weights bus", 64'(last_weights), 64'(pk_w(2, 0, -1, 0, 0)));
    check("basic layer_outputs", 64'(layer_outputs), 64'({10'd0, 10'd0, 10'h3FF, 10'd6}));
    check("basic layer_overflow", 64'(layer_overflow), 64'(0));
    tick();
    check("basic valid one cycle", 64'(layer_valid), 64'(0));
    check("basic cleared", 64'(layer_outputs), 64'(0));

    // Skewed neuron channels
    new_test(); wdelay = 3;
    rom[0] = pk_w(3, 4, 0, 0, 0); sum_tab[0] = 10'd43; ovf_tab[0] = 0;
    issue(4'd2, 3'd1, pk_a(5, 7, 0, 0, 0));
    wait_layer("skew", cyc);
    check("skew latency", 64'(cyc), 64'(8));
    check("skew number valid cycles", 64'(hi_n), 64'(1));
    check("skew inputs valid cycles", 64'(hi_i), 64'(1));
    check("skew weights valid cycles", 64'(hi_w), 64'(4));
    check("skew wait overlap", 64'(viol), 64'(0));
    check("skew layer_outputs", 64'(layer_outputs), 64'(43));
    tick();

    // Zero output count
    new_test();
    issue(4'd3, 3'd0, pk_a(1, 2, 3, 0, 0));
    wait_layer("zero", cyc);
    check("zero latency", 64'(cyc), 64'(1));
    check("zero outputs", 64'({layer_outputs, layer_overflow}), 64'(0));
    check("zero no fetch", 64'(addr_log.size()), 64'(0));
    tick();

    // Clamping and overflow
    new_test();
    for (int i = 0; i < ON; i++) rom[i] = pk_w(1, 1, 1, 1, 1);
    sum_tab[0] = 10'd5; sum_tab[1] = 10'd200; sum_tab[2] = 10'd7; sum_tab[3] = 10'd9;
    ovf_tab[0] = 0; ovf_tab[1] = 1; ovf_tab[2] = 0; ovf_tab[3] = 0;
    issue(4'd7, 3'd4, pk_a(1, 1, 1, 1, 1));
    wait_layer("clamp", cyc);
    check("clamp latency", 64'(cyc), 64'(17));
    check("clamp input_number", 64'(last_num), 64'(5));
    check("clamp addr count", 64'(addr_log.size()), 64'(4));
    check("clamp layer_overflow", 64'(layer_overflow), 64'(4'b0010));
    check("clamp layer_outputs", 64'(layer_outputs), 64'({10'd9, 10'd7, 10'd200, 10'd5}));
    tick();

    // Backpressure in DONE
    new_test(); layer_ready = 1'b0;
    rom[0] = pk_w(5, 0, 0, 0, 0); sum_tab[0] = 10'd20; ovf_tab[0] = 1;
    issue(4'd1, 3'd1, pk_a(4, 0, 0, 0, 0));
    wait_layer("bp", cyc);
    snap = layer_outputs; bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!layer_valid || layer_outputs !== snap || layer_overflow !== 4'b0001 ||
          cmd_ready || activations_ready) bad++;
    end
    check("bp held stable", 64'(bad), 64'(0));
    check("bp result", 64'(snap), 64'(20));
    layer_ready = 1'b1;
    tick();
    check("bp released", 64'({layer_valid, cmd_ready, activations_ready}), 64'(3'b011));

    // Reset during row 2 WAIT
    new_test(); stall_row = 2; lv_before = lv_count;
    rom[0] = pk_w(3, 0, 0, 0, 0); rom[1] = pk_w(4, 0, 0, 0, 0);
    rom[2] = pk_w(5, 0, 0, 0, 0); rom[3] = pk_w(6, 0, 0, 0, 0);
    sum_tab[0] = 10'd6; sum_tab[1] = 10'd8; sum_tab[2] = 10'd10; sum_tab[3] = 10'd12;
    for (int i = 0; i < ON; i++) ovf_tab[i] = 0;
    issue(4'd1, 3'd4, pk_a(2, 0, 0, 0, 0));
    cyc = 0;
    do begin tick(); cyc++; end while (!(neuron_sum_ready && nidx == 2) && cyc < 100);
    check("rstmid reached row2 wait", 64'(neuron_sum_ready), 64'(1));
    check("rstmid partial slots", 64'(layer_outputs), 64'({10'd0, 10'd0, 10'd8, 10'd6}));
    tick(); tick();
    rst = 1'b1; #1;
    check("rstmid readies", 64'({cmd_ready, activations_ready}), 64'(2'b11));
    check("rstmid handshake outs", 64'({neuron_sum_ready, layer_valid, weight_addr_valid}), 64'(0));
    check("rstmid cleared", 64'({layer_outputs, layer_overflow, weight_addr}), 64'(0));
    tick();
    rst = 1'b0;
    check("rstmid no layer_valid", 64'(lv_count - lv_before), 64'(0));
    new_test();
    rom[0] = pk_w(3, 4, 0, 0, 0); sum_tab[0] = 10'd11; ovf_tab[0] = 0;
    issue(4'd2, 3'd1, pk_a(1, 2, 0, 0, 0));
    wait_layer("post-reset", cyc);
    check("post-reset latency", 64'(cyc), 64'(5));
    check("post-reset layer_outputs", 64'(layer_outputs), 64'(11));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
